// File: rtl/cmp_search_ctrl.sv
// Sequenced tag-search controller: one shared WIDTH-bit comparator scans a DEPTH-entry tag table.
// Optional macro CMP_SEARCH_MRU_EN starts each search at the most recently hit index.
module cmp_search_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] key,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(DEPTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] key_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] hit_idx_q;
  logic [IDX_W-1:0] start_idx;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic             match;

`ifdef CMP_SEARCH_MRU_EN
  logic [IDX_W-1:0] mru_q;
  assign start_idx = mru_q;
`else
  assign start_idx = '0;
`endif

  // Compare sees the table as committed at the previous edge, so earlier writes are visible.
  assign match = valid_q[idx_q] && (tag_q[idx_q] == key_q);

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit     = hit_q;
  assign hit_idx = hit_idx_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_data;
    end
  end

  // clear takes priority so a same-edge write leaves its entry invalid.
  always_comb begin
    valid_d = valid_q;
    if (clear) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      key_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
`ifdef CMP_SEARCH_MRU_EN
      mru_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            key_q   <= key;
            idx_q   <= start_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (match) begin
            hit_q     <= 1'b1;
            hit_idx_q <= idx_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
`ifdef CMP_SEARCH_MRU_EN
            mru_q     <= idx_q;
`endif
          end else if (cnt_q == LAST_CNT) begin
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            // Power-of-two DEPTH makes the natural index overflow the modulo wrap.
            idx_q <= idx_q + IDX_W'(1);
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl: vector table of searches plus hand-written multi-cycle sequences.
module tb_cmp_search_ctrl;

  logic        clk_tb;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic        clear;
  logic        start;
  logic [31:0] key;
  logic        busy;
  logic        done;
  logic        hit;
  logic [2:0]  hit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] k;
    logic        exp_hit;
    int          exp_idx;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  cmp_search_ctrl #(.DEPTH(8), .IDX_W(3), .WIDTH(32)) dut (
    .clock   (clk_tb),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .clear   (clear),
    .start   (start),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic write_entry(input int i, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_idx  = 3'(i);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic fill_table();
    for (int i = 0; i < 8; i++) write_entry(i, 32'h100 + 32'(i));
  endtask

  task automatic clear_table();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Edge 0 samples start; latency is the edge index after which done is first seen.
  task automatic do_search(input string nm, input logic [31:0] k, input logic exp_hit,
                           input int exp_idx, input int exp_lat);
    int lat;
    bit busy_ok;
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
    key   = ~k;
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < 30) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " hit"}, 32'(hit), 32'(exp_hit));
    check({nm, " hit_idx"}, 32'(hit_idx), 32'(exp_idx));
    check({nm, " busy"}, 32'(busy_ok && !busy), 32'd1);
    tick();
    check({nm, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;
    logic [2:0] idx_at_done;

    vecs[0] = '{32'h0000_0103, 1'b1, 3, 4};
    vecs[1] = '{32'hDEAD_BEEF, 1'b0, 0, 8};
    vecs[2] = '{32'h0000_0100, 1'b1, 0, 1};
    vecs[3] = '{32'h0000_0107, 1'b1, 7, 8};
    vecs[4] = '{32'h0000_0108, 1'b0, 0, 8};
    vecs[5] = '{32'h0000_0105, 1'b1, 5, 6};

    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    clear   = 1'b0;
    start   = 1'b0;
    key     = '0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hit", 32'(hit), 32'd0);
    check("reset hit_idx", 32'(hit_idx), 32'd0);
    @(negedge clk_tb);
    reset_n = 1'b1;
    tick();

`ifdef CMP_SEARCH_MRU_EN
    fill_table();
    do_search("mru first", 32'h105, 1'b1, 5, 6);
    do_search("mru next", 32'h106, 1'b1, 6, 2);
    do_search("mru wrap", 32'h101, 1'b1, 1, 4);
    do_search("mru miss", 32'hBAD0_0000, 1'b0, 0, 8);
`else
    fill_table();
    for (int v = 0; v < 6; v++) begin
      do_search($sformatf("vec%0d", v), vecs[v].k, vecs[v].exp_hit, vecs[v].exp_idx, vecs[v].exp_lat);
    end

    // Cleared entries keep their tags but must never hit.
    clear_table();
    do_search("after clear", 32'h100, 1'b0, 0, 8);

    write_entry(2, 32'hCAFE_0000);
    write_entry(5, 32'hCAFE_0000);
    do_search("dup first", 32'hCAFE_0000, 1'b1, 2, 3);

    clear   = 1'b1;
    wr_en   = 1'b1;
    wr_idx  = 3'd2;
    wr_data = 32'hCAFE_0000;
    tick();
    clear   = 1'b0;
    wr_en   = 1'b0;
    write_entry(5, 32'hCAFE_0000);
    do_search("clear wins", 32'hCAFE_0000, 1'b1, 5, 6);

    // Second start two cycles into a search must be ignored.
    clear_table();
    fill_table();
    start = 1'b1;
    key   = 32'h105;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    key   = 32'h101;
    tick();
    start = 1'b0;
    ndone = 0;
    lat   = 2;
    idx_at_done = '0;
    for (int c = 0; c < 15; c++) begin
      if (done) begin
        ndone++;
        idx_at_done = hit_idx;
      end
      if (ndone == 0) lat++;
      tick();
    end
    check("restart done count", 32'(ndone), 32'd1);
    check("restart hit_idx", 32'(idx_at_done), 32'd5);
    check("restart latency", 32'(lat), 32'd6);

    // Key written into entry 6 while scanning idx 2.
    start = 1'b1;
    key   = 32'h0000_ABCD;
    tick();
    start = 1'b0;
    tick();
    tick();
    wr_en   = 1'b1;
    wr_idx  = 3'd6;
    wr_data = 32'h0000_ABCD;
    tick();
    wr_en = 1'b0;
    lat   = 3;
    while (!done && lat < 30) begin
      tick();
      lat++;
    end
    check("late write latency", 32'(lat), 32'd7);
    check("late write hit", 32'(hit), 32'd1);
    check("late write hit_idx", 32'(hit_idx), 32'd6);
    tick();

    // Asynchronous reset at idx 4 of a search.
    start = 1'b1;
    key   = 32'hDEAD_0000;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("pre-reset busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst hit", 32'(hit), 32'd0);
    check("async rst hit_idx", 32'(hit_idx), 32'd0);
    #20;
    @(negedge clk_tb);
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("no done after reset", 32'(ndone), 32'd0);
    do_search("valid reset", 32'h100, 1'b0, 0, 8);
    fill_table();
    do_search("post reset", 32'h102, 1'b1, 2, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Sequenced tag-search controller for the processor: holds a DEPTH-entry table of WIDTH-bit tags with valid bits.
- Scans the table for a key using one shared WIDTH-bit equality comparator, one entry per cycle.
- Used for store-address match and branch-target tag lookups, where a single comparator replaces DEPTH parallel comparators.
- start/busy/done handshake toward the requesting pipeline stage.

Parameters:
DEPTH, 8, number of table entries (power of two, >=2)
IDX_W, 3, index width, equals log2(DEPTH)
WIDTH, 32, tag/key width; the single comparator is WIDTH bits

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous reset, active-low
wr_en  input  1  write tag into table this edge
wr_idx  input  IDX_W  entry written
wr_data  input  WIDTH  tag value; the entry's valid bit is set on write
clear  input  1  invalidate all entries this edge
start  input  1  request a search; sampled only in IDLE
key  input  WIDTH  search key; latched on accepted start
busy  output  1  high while in SEARCH
done  output  1  one-cycle pulse, result valid
hit  output  1  match found (held)
hit_idx  output  IDX_W  lowest-scanned matching index (held)

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; all valid bits=0; busy=0, done=0, hit=0, hit_idx=0; scan counter=0; key register=0. Tag storage contents don't care.
- Reset asserted mid-search aborts the search immediately; no done pulse follows.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: start=1 -> latch key, scan idx=start index (0), go to SEARCH. hit/hit_idx keep their previous values until DONE.
  - SEARCH: busy=1. Comparator compares tag[idx] with the latched key.
    - valid[idx] && equal -> hit=1, hit_idx=idx, go to DONE.
    - Otherwise, if this was the DEPTH-th entry scanned -> hit=0, hit_idx=0, go to DONE.
    - Otherwise idx advances by 1, modulo DEPTH.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally. start in DONE is ignored.
- Latency (edge 0 = edge sampling start, outputs registered):
  - Hit at the k-th scanned entry (k from 0): done high in the cycle after edge k+1.
  - Miss: done high in the cycle after edge DEPTH.
- start while busy or in DONE: ignored, no queuing. key changes after acceptance have no effect.
- Table writes are allowed in any state and commit at the edge. A SEARCH compare uses the table contents present that cycle, so a write to a not-yet-scanned entry is seen.
- clear and wr_en on the same edge: clear wins; the written entry ends invalid. clear during SEARCH: the search continues and all remaining compares miss.
- Invalid entries never hit, even if the stored tag equals the key.
- Multiple matching entries: the first one scanned wins.

Optional Feature:
- Macro CMP_SEARCH_MRU_EN.
- Defined: an mru register (reset 0) is updated to hit_idx on every hit. Each search starts at mru and wraps modulo DEPTH, still scanning at most DEPTH entries. With duplicate matches, the first matching entry at or after mru in wrap order wins.
- Not defined: every search starts at index 0; no mru register.

Test Plan:
- Reset, write entries i=0..7 with 0x100+i, start key=0x103 -> busy high edges 1-3, done pulse after edge 4, hit=1, hit_idx=3.
- Same table, key=0xDEADBEEF -> done after edge 8, hit=0, hit_idx=0. Then clear and search key=0x100 -> miss (valid bits cleared).
- Entries 2 and 5 both hold 0xCAFE0000, key=0xCAFE0000 (MRU off) -> hit_idx=2, done after edge 3. Entry 2 written and cleared on the same edge -> hit_idx=5.
- Second start pulse two cycles into a search -> ignored, exactly one done. A write of the key into entry 6 during a scan at idx 2 -> hit_idx=6.
- reset_n driven low asynchronously mid-search (idx=4) -> busy, hit and done go 0 immediately; no done after release; the next search works normally.
- CMP_SEARCH_MRU_EN defined: after a hit at 5, search the tag in entry 6 -> done after edge 2, hit_idx=6. Search the tag in entry 1 -> wraps 6,7,0,1, done after edge 4.
